// File: rtl/axi_ost_arbiter.sv
// Round-robin AW/AR arbiter in front of the outstanding/deadlock tracker; stalled masters park until a response retires.
// Optional starvation priority is enabled with AXI_OST_ARB_STARVE_EN.
module axi_ost_arbiter #(
    parameter int unsigned NUM_MASTER      = 8,
    parameter int unsigned NUM_MASTER_LOG2 = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1,
    parameter int unsigned NUM_SLAVE_LOG2  = 3,
    parameter int unsigned W_ID            = 6,
    parameter int unsigned W_PAYLOAD       = 64,
    parameter int unsigned STARVE_LIMIT    = 15
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [NUM_MASTER-1:0]                m_valid_i,
    output logic [NUM_MASTER-1:0]                m_ready_o,
    input  logic [NUM_MASTER*W_ID-1:0]           m_id_i,
    input  logic [NUM_MASTER*NUM_SLAVE_LOG2-1:0] m_slave_i,
    input  logic [NUM_MASTER*W_PAYLOAD-1:0]      m_payload_i,
    output logic                                 trk_valid_o,
    output logic                                 trk_accept_o,
    output logic [W_ID-1:0]                      trk_id_o,
    output logic [NUM_SLAVE_LOG2-1:0]            trk_slave_o,
    input  logic                                 ost_stall_i,
    input  logic                                 deadlock_stall_i,
    input  logic                                 rsp_retire_i,
    output logic                                 s_valid_o,
    input  logic                                 s_ready_i,
    output logic [W_ID-1:0]                      s_id_o,
    output logic [NUM_SLAVE_LOG2-1:0]            s_slave_o,
    output logic [W_PAYLOAD-1:0]                 s_payload_o,
    output logic [NUM_MASTER_LOG2-1:0]           s_master_o,
    output logic [15:0]                          stall_cnt_o,
    output logic                                 starve_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam int unsigned W_CNT  = 16;

    logic [1:0]                 state, state_nxt;
    logic [NUM_MASTER_LOG2-1:0] ptr, ptr_nxt, cand, cand_nxt, rr_pick;
    logic                       rr_found;
    logic [NUM_MASTER-1:0]      blocked, blocked_nxt, elig;
    logic [W_CNT-1:0]           stall_cnt_nxt;
    logic                       stall;
    logic [W_ID-1:0]            id_arr    [NUM_MASTER];
    logic [NUM_SLAVE_LOG2-1:0]  slave_arr [NUM_MASTER];
    logic [W_PAYLOAD-1:0]       pay_arr   [NUM_MASTER];

    assign elig  = m_valid_i & ~blocked;
    assign stall = ost_stall_i | deadlock_stall_i;

    // Unpack per-master request fields.
    always_comb begin
        for (int k = 0; k < NUM_MASTER; k++) begin
            id_arr[k]    = m_id_i[k*W_ID +: W_ID];
            slave_arr[k] = m_slave_i[k*NUM_SLAVE_LOG2 +: NUM_SLAVE_LOG2];
            pay_arr[k]   = m_payload_i[k*W_PAYLOAD +: W_PAYLOAD];
        end
    end

    // First eligible master at or after ptr, wrapping.
    always_comb begin
        logic [NUM_MASTER_LOG2-1:0] idx;
        rr_found = 1'b0;
        rr_pick  = '0;
        idx      = '0;
        for (int unsigned i = 0; i < NUM_MASTER; i++) begin
            idx = NUM_MASTER_LOG2'((32'(ptr) + i) % NUM_MASTER);
            if (!rr_found && elig[idx]) begin
                rr_pick  = idx;
                rr_found = 1'b1;
            end
        end
    end

`ifdef AXI_OST_ARB_STARVE_EN
    localparam int unsigned W_RETRY = 8;

    logic [W_RETRY-1:0]         retry [NUM_MASTER];
    logic [NUM_MASTER-1:0]      starving;
    logic [NUM_MASTER_LOG2-1:0] starve_idx;
    logic                       starve_found;

    always_comb begin
        starve_idx   = '0;
        starve_found = 1'b0;
        for (int k = 0; k < NUM_MASTER; k++) begin
            starving[k] = 32'(retry[k]) >= STARVE_LIMIT;
            if (!starve_found && starving[k]) begin
                starve_idx   = NUM_MASTER_LOG2'(k);
                starve_found = 1'b1;
            end
        end
    end

    assign starve_o = |starving;

    // Retry counters: bump on each stall of the candidate, clear on its issue.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int k = 0; k < NUM_MASTER; k++) retry[k] <= '0;
        end else if (state == S_CHECK && stall) begin
            if (retry[cand] != '1) retry[cand] <= retry[cand] + W_RETRY'(1);
        end else if (state == S_ISSUE && s_ready_i) begin
            retry[cand] <= '0;
        end
    end
`else
    assign starve_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= S_IDLE;
            ptr         <= '0;
            cand        <= '0;
            blocked     <= '0;
            stall_cnt_o <= '0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            cand        <= cand_nxt;
            blocked     <= blocked_nxt;
            stall_cnt_o <= stall_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        cand_nxt      = cand;
        blocked_nxt   = blocked;
        stall_cnt_nxt = stall_cnt_o;
        m_ready_o     = '0;
        trk_valid_o   = 1'b0;
        trk_accept_o  = 1'b0;
        trk_id_o      = '0;
        trk_slave_o   = '0;
        s_valid_o     = 1'b0;
        s_id_o        = '0;
        s_slave_o     = '0;
        s_payload_o   = '0;
        s_master_o    = '0;

        case (state)
            S_IDLE: begin
`ifdef AXI_OST_ARB_STARVE_EN
                // A valid starved master excludes everyone else until it issues.
                if (starve_o && m_valid_i[starve_idx]) begin
                    if (!blocked[starve_idx]) begin
                        cand_nxt  = starve_idx;
                        state_nxt = S_CHECK;
                    end
                end else
`endif
                if (rr_found) begin
                    cand_nxt  = rr_pick;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                trk_valid_o = 1'b1;
                trk_id_o    = id_arr[cand];
                trk_slave_o = slave_arr[cand];
                if (stall) begin
                    blocked_nxt[cand] = 1'b1;
                    if (stall_cnt_o != '1) stall_cnt_nxt = stall_cnt_o + W_CNT'(1);
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                trk_valid_o = 1'b1;
                trk_id_o    = id_arr[cand];
                trk_slave_o = slave_arr[cand];
                s_valid_o   = 1'b1;
                s_id_o      = id_arr[cand];
                s_slave_o   = slave_arr[cand];
                s_payload_o = pay_arr[cand];
                s_master_o  = cand;
                if (s_ready_i) begin
                    m_ready_o[cand]   = 1'b1;
                    trk_accept_o      = 1'b1;
                    blocked_nxt[cand] = 1'b0;
                    ptr_nxt   = (cand == NUM_MASTER_LOG2'(NUM_MASTER - 1)) ? '0
                                                                           : cand + NUM_MASTER_LOG2'(1);
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // A retired response may relax any stall, so every parked master gets another try.
        if (rsp_retire_i) blocked_nxt = '0;
    end

endmodule

// File: tb/tb_axi_ost_arbiter.sv
// Directed self-checking bench for axi_ost_arbiter (default build).
module tb_axi_ost_arbiter;

    localparam int NM = 8;
    localparam int WI = 6;
    localparam int WS = 3;
    localparam int WP = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NM-1:0]   m_valid = '0;
    logic [NM-1:0]   m_ready;
    logic [NM*WI-1:0] m_id;
    logic [NM*WS-1:0] m_slave;
    logic [NM*WP-1:0] m_payload;
    logic            trk_valid, trk_accept;
    logic [WI-1:0]   trk_id;
    logic [WS-1:0]   trk_slave;
    logic            ost_stall = 1'b0;
    logic            dl_stall = 1'b0;
    logic            retire = 1'b0;
    logic            s_valid;
    logic            s_ready = 1'b0;
    logic [WI-1:0]   s_id;
    logic [WS-1:0]   s_slave;
    logic [WP-1:0]   s_payload;
    logic [2:0]      s_master;
    logic [15:0]     stall_cnt;
    logic            starve;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axi_ost_arbiter dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .m_valid_i(m_valid), .m_ready_o(m_ready),
        .m_id_i(m_id), .m_slave_i(m_slave), .m_payload_i(m_payload),
        .trk_valid_o(trk_valid), .trk_accept_o(trk_accept),
        .trk_id_o(trk_id), .trk_slave_o(trk_slave),
        .ost_stall_i(ost_stall), .deadlock_stall_i(dl_stall), .rsp_retire_i(retire),
        .s_valid_o(s_valid), .s_ready_i(s_ready),
        .s_id_o(s_id), .s_slave_o(s_slave), .s_payload_o(s_payload),
        .s_master_o(s_master), .stall_cnt_o(stall_cnt), .starve_o(starve)
    );

    function automatic logic [WI-1:0] id_of(input int k);
        return WI'(k + 8);
    endfunction

    function automatic logic [WS-1:0] slv_of(input int k);
        return WS'(7 - k);
    endfunction

    function automatic logic [WP-1:0] pay_of(input int k);
        return {32'hA5A5_0000 | 32'(k), 32'h1234_0000 | 32'(k * 3)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; m_valid = '0; s_ready = 1'b0;
        ost_stall = 1'b0; dl_stall = 1'b0; retire = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        n_checks++; if (s_valid !== 1'b0) begin n_errors++; $display("FAIL reset_s_valid got %b exp 0", s_valid); end
        n_checks++; if (trk_valid !== 1'b0) begin n_errors++; $display("FAIL reset_trk_valid got %b exp 0", trk_valid); end
        n_checks++; if (m_ready !== 8'h00) begin n_errors++; $display("FAIL reset_m_ready got %h exp 00", m_ready); end
        n_checks++; if (s_payload !== 64'h0) begin n_errors++; $display("FAIL reset_s_payload got %h exp 0", s_payload); end
        n_checks++; if (stall_cnt !== 16'h0) begin n_errors++; $display("FAIL reset_stall_cnt got %h exp 0", stall_cnt); end
        n_checks++; if (dut.state !== 2'd0 || dut.blocked !== 8'h00 || dut.ptr !== 3'd0) begin
            n_errors++; $display("FAIL reset_state got state=%0d blocked=%h ptr=%0d exp 0/00/0", dut.state, dut.blocked, dut.ptr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        m_valid = 8'h04; s_ready = 1'b1;
        step();
        n_checks++; if (trk_valid !== 1'b1 || trk_id !== id_of(2) || trk_slave !== slv_of(2) || s_valid !== 1'b0) begin
            n_errors++; $display("FAIL single_check got tv=%b id=%h sl=%0d sv=%b exp 1/%h/%0d/0", trk_valid, trk_id, trk_slave, s_valid, id_of(2), slv_of(2));
        end
        step();
        n_checks++; if (s_valid !== 1'b1 || s_master !== 3'd2 || m_ready !== 8'b0000_0100 || trk_accept !== 1'b1) begin
            n_errors++; $display("FAIL single_issue got sv=%b m=%0d mr=%b ta=%b exp 1/2/00000100/1", s_valid, s_master, m_ready, trk_accept);
        end
        n_checks++; if (s_id !== id_of(2) || s_slave !== slv_of(2) || s_payload !== pay_of(2)) begin
            n_errors++; $display("FAIL single_fields got %h/%0d/%h exp %h/%0d/%h", s_id, s_slave, s_payload, id_of(2), slv_of(2), pay_of(2));
        end
        m_valid = 8'h00;
        step();
        n_checks++; if (m_ready !== 8'h00 || s_valid !== 1'b0 || dut.ptr !== 3'd3) begin
            n_errors++; $display("FAIL single_after got mr=%h sv=%b ptr=%0d exp 00/0/3", m_ready, s_valid, dut.ptr);
        end
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 1, 3, 0, 1, 3};
        do_reset();
        m_valid = 8'b0000_1011; s_ready = 1'b1;
        for (int g = 0; g < 6; g++) begin
            step();
            n_checks++; if (s_valid !== 1'b0) begin n_errors++; $display("FAIL rr_gap%0d got s_valid %b exp 0", g, s_valid); end
            step();
            n_checks++; if (s_valid !== 1'b1 || s_master !== 3'(order[g]) || m_ready !== 8'(1 << order[g])) begin
                n_errors++; $display("FAIL rr_grant%0d got sv=%b m=%0d mr=%b exp 1/%0d", g, s_valid, s_master, m_ready, order[g]);
            end
            step();
        end
        m_valid = '0;
`ifndef AXI_OST_ARB_STARVE_EN
        n_checks++; if (starve !== 1'b0) begin n_errors++; $display("FAIL rr_starve got %b exp 0", starve); end
`endif
    endtask

    task automatic test_stall_retire();
        do_reset();
        m_valid = 8'h12; s_ready = 1'b1;
        step();
        n_checks++; if (trk_valid !== 1'b1 || trk_id !== id_of(1)) begin
            n_errors++; $display("FAIL stall_cand got tv=%b id=%h exp 1/%h", trk_valid, trk_id, id_of(1));
        end
        dl_stall = 1'b1;
        step();
        dl_stall = 1'b0;
        n_checks++; if (dut.blocked !== 8'h02 || stall_cnt !== 16'd1 || s_valid !== 1'b0) begin
            n_errors++; $display("FAIL stall_block got blk=%h cnt=%0d sv=%b exp 02/1/0", dut.blocked, stall_cnt, s_valid);
        end
        step(); step();
        n_checks++; if (s_valid !== 1'b1 || s_master !== 3'd4 || m_ready !== 8'h10) begin
            n_errors++; $display("FAIL stall_other got sv=%b m=%0d mr=%h exp 1/4/10", s_valid, s_master, m_ready);
        end
        m_valid = 8'h02;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (trk_valid !== 1'b0 || s_valid !== 1'b0) begin
                n_errors++; $display("FAIL stall_park%0d got tv=%b sv=%b exp 0/0", i, trk_valid, s_valid);
            end
        end
        retire = 1'b1;
        step();
        retire = 1'b0;
        n_checks++; if (dut.blocked !== 8'h00) begin n_errors++; $display("FAIL stall_unblock got %h exp 00", dut.blocked); end
        step(); step();
        n_checks++; if (s_valid !== 1'b1 || s_master !== 3'd1 || m_ready !== 8'h02 || stall_cnt !== 16'd1) begin
            n_errors++; $display("FAIL stall_retry got sv=%b m=%0d mr=%h cnt=%0d exp 1/1/02/1", s_valid, s_master, m_ready, stall_cnt);
        end
        m_valid = 8'h00;
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        m_valid = 8'h40; s_ready = 1'b0;
        step(); step();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (s_valid !== 1'b1 || s_payload !== pay_of(6) || s_master !== 3'd6 || m_ready !== 8'h00 || trk_accept !== 1'b0) begin
                n_errors++; $display("FAIL bp_hold%0d got sv=%b p=%h m=%0d mr=%h ta=%b exp 1/%h/6/00/0", i, s_valid, s_payload, s_master, m_ready, trk_accept, pay_of(6));
            end
            step();
        end
        s_ready = 1'b1;
        #1;
        n_checks++; if (m_ready !== 8'h40 || trk_accept !== 1'b1) begin
            n_errors++; $display("FAIL bp_accept got mr=%h ta=%b exp 40/1", m_ready, trk_accept);
        end
        step();
        m_valid = 8'h00;
        n_checks++; if (m_ready !== 8'h00 || trk_accept !== 1'b0 || s_valid !== 1'b0) begin
            n_errors++; $display("FAIL bp_after got mr=%h ta=%b sv=%b exp 00/0/0", m_ready, trk_accept, s_valid);
        end
    endtask

    task automatic test_retire_race_and_reset();
        do_reset();
        m_valid = 8'h04; s_ready = 1'b0;
        step();
        ost_stall = 1'b1; retire = 1'b1;
        step();
        ost_stall = 1'b0; retire = 1'b0;
        n_checks++; if (dut.blocked !== 8'h00 || stall_cnt !== 16'd1 || trk_valid !== 1'b0) begin
            n_errors++; $display("FAIL race_clear got blk=%h cnt=%0d tv=%b exp 00/1/0", dut.blocked, stall_cnt, trk_valid);
        end
        step(); step();
        n_checks++; if (s_valid !== 1'b1 || s_master !== 3'd2) begin
            n_errors++; $display("FAIL race_reissue got sv=%b m=%0d exp 1/2", s_valid, s_master);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (s_valid !== 1'b0 || trk_valid !== 1'b0 || dut.state !== 2'd0 || stall_cnt !== 16'd0) begin
            n_errors++; $display("FAIL async_reset got sv=%b tv=%b st=%0d cnt=%0d exp 0/0/0/0", s_valid, trk_valid, dut.state, stall_cnt);
        end
        m_valid = 8'h00;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < NM; k++) begin
            m_id[k*WI +: WI]      = id_of(k);
            m_slave[k*WS +: WS]   = slv_of(k);
            m_payload[k*WP +: WP] = pay_of(k);
        end
        test_reset();
        test_single();
        test_round_robin();
        test_stall_retire();
        test_backpressure();
        test_retire_race_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
